// File: rtl/pattern_sequencer_pkg.sv
// pattern_sequencer_pkg: pattern IDs, ramp-step FSM states and pattern helpers.
package pattern_sequencer_pkg;
  localparam logic [7:0] PAT_NONE     = 8'd0;
  localparam logic [7:0] PAT_BORDER   = 8'd1;
  localparam logic [7:0] PAT_MOIRE_X  = 8'd2;
  localparam logic [7:0] PAT_MOIRE_Y  = 8'd3;
  localparam logic [7:0] PAT_RAMP     = 8'd4;
  localparam logic [7:0] NUM_PATTERNS = 8'd5;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_HOLD = 2'd2
  } step_state_e;
  function automatic logic [7:0] next_pattern(input logic [7:0] p);
    return (p >= NUM_PATTERNS - 8'd1) ? PAT_NONE : p + 8'd1;
  endfunction
endpackage

// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if: sync, line width, host config and generator-facing outputs.
interface pattern_sequencer_if #(
  parameter int B = 8,
  parameter int X_BITS = 13,
  parameter int FRACTIONAL_BITS = 12
);
  logic                         vn_in;
  logic [X_BITS-1:0]            total_active_pix;
  logic                         cfg_wr;
  logic                         cfg_auto;
  logic [7:0]                   cfg_pattern;
  logic [7:0]                   cfg_dwell;
  logic                         cfg_busy;
  logic [7:0]                   pattern;
  logic [B+FRACTIONAL_BITS-1:0] ramp_step;
  logic                         step_valid;
  logic [15:0]                  frame_count;
  modport master (
    output vn_in, total_active_pix, cfg_wr, cfg_auto, cfg_pattern, cfg_dwell,
    input  cfg_busy, pattern, ramp_step, step_valid, frame_count
  );
  modport slave (
    input  vn_in, total_active_pix, cfg_wr, cfg_auto, cfg_pattern, cfg_dwell,
    output cfg_busy, pattern, ramp_step, step_valid, frame_count
  );
endinterface

// File: rtl/pattern_step_div.sv
// pattern_step_div: restoring divider of 2^DIVIDEND_W by divisor, one quotient bit per cycle.
module pattern_step_div
  import pattern_sequencer_pkg::*;
#(
  parameter int DIVIDEND_W = 20,
  parameter int DIVISOR_W = 13,
  localparam int Q_W = DIVIDEND_W + 1,
  localparam int CNT_W = $clog2(Q_W + 1)
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [Q_W-1:0]       quotient,
  output logic                 done,
  output logic                 saturate
);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIVISOR_W-1:0] div_q, div_d, rem_q, rem_d;
  logic [Q_W-1:0]       quo_q, quo_d;
  logic [DIVISOR_W:0]   r;
  logic                 ge;
  // The dividend is a single 1 followed by zeros, so only the first iteration shifts in a 1.
  always_comb begin
    r = {rem_q, cnt_q == CNT_W'(Q_W)};
    ge = r >= {1'b0, div_q};
    cnt_d = cnt_q;
    div_d = div_q;
    rem_d = rem_q;
    quo_d = quo_q;
    if (start) begin
      cnt_d = CNT_W'(Q_W);
      div_d = divisor;
      rem_d = '0;
      quo_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      rem_d = ge ? DIVISOR_W'(r - {1'b0, div_q}) : r[DIVISOR_W-1:0];
      quo_d = {quo_q[Q_W-2:0], ge};
    end
  end
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      cnt_q <= '0;
      div_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end
  // done marks the final iteration; quotient holds the result from the following cycle.
  assign done = cnt_q == CNT_W'(1);
  assign quotient = quo_q;
  assign saturate = div_q <= DIVISOR_W'(1);
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: per-frame pattern selection and ramp-step computation for the test-pattern generator.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int B = 8,
  parameter int X_BITS = 13,
  parameter int FRACTIONAL_BITS = 12,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input logic                clk_in,
  input logic                reset_n,
  pattern_sequencer_if.slave bus
);
  localparam int STEP_W = B + FRACTIONAL_BITS;
  logic              vn_q, vn_d, vn_dly_q, vn_dly_d, fb_q, fb_d;
  logic              auto_sh_q, auto_sh_d, busy_q, busy_d, auto_q, auto_d;
  logic [7:0]        pat_sh_q, pat_sh_d, dwell_sh_q, dwell_sh_d;
  logic [7:0]        cnt_q, cnt_d, pattern_q, pattern_d;
  logic [8:0]        cnt_inc, dwell_eff;
  logic [15:0]       frame_q, frame_d;
  step_state_e       state_q, state_d;
  logic [X_BITS-1:0] width_q, width_d;
  logic              first_q, first_d, valid_q, valid_d;
  logic              div_start, div_done, div_sat, width_changed;
  logic [STEP_W-1:0] ramp_q, ramp_d;
  logic [STEP_W:0]   quotient;
  pattern_step_div #(.DIVIDEND_W(STEP_W), .DIVISOR_W(X_BITS)) u_div (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .start    (div_start),
    .divisor  (bus.total_active_pix),
    .quotient (quotient),
    .done     (div_done),
    .saturate (div_sat)
  );
  always_comb begin
    vn_d = SYNC_ACTIVE_LOW ? ~bus.vn_in : bus.vn_in;
    vn_dly_d = vn_q;
    fb_d = vn_q & ~vn_dly_q;
    auto_sh_d = bus.cfg_wr ? bus.cfg_auto : auto_sh_q;
    pat_sh_d = bus.cfg_wr ? bus.cfg_pattern : pat_sh_q;
    dwell_sh_d = bus.cfg_wr ? bus.cfg_dwell : dwell_sh_q;
    busy_d = bus.cfg_wr | (busy_q & ~fb_q);
    dwell_eff = (dwell_sh_q == 8'd0) ? 9'd1 : {1'b0, dwell_sh_q};
    cnt_inc = {1'b0, cnt_q} + 9'd1;
    frame_d = fb_q ? frame_q + 16'd1 : frame_q;
    auto_d = fb_q ? auto_sh_q : auto_q;
    pattern_d = pattern_q;
    cnt_d = cnt_q;
    // The shadow read here is the pre-write value, so a write coinciding with fb waits a frame.
    if (fb_q) begin
      if (!auto_sh_q) pattern_d = pat_sh_q;
      else if (!auto_q) begin
        pattern_d = PAT_NONE;
        cnt_d = '0;
      end else if (cnt_inc >= dwell_eff) begin
        pattern_d = next_pattern(pattern_q);
        cnt_d = '0;
      end else cnt_d = cnt_inc[7:0];
    end
    width_changed = bus.total_active_pix != width_q;
    state_d = state_q;
    width_d = width_q;
    first_d = first_q;
    ramp_d = ramp_q;
    div_start = 1'b0;
    valid_d = valid_q & ~width_changed;
    case (state_q)
      ST_IDLE: if (first_q || width_changed) begin
        state_d = ST_DIV;
        width_d = bus.total_active_pix;
        first_d = 1'b0;
        div_start = 1'b1;
      end
      ST_DIV: if (div_done) state_d = ST_HOLD;
      ST_HOLD: if (fb_q) begin
        state_d = ST_IDLE;
        if (!width_changed) begin
          ramp_d = (div_sat | quotient[STEP_W]) ? '1 : quotient[STEP_W-1:0];
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      vn_q       <= 1'b0;
      vn_dly_q   <= 1'b0;
      fb_q       <= 1'b0;
      auto_sh_q  <= 1'b0;
      pat_sh_q   <= PAT_NONE;
      dwell_sh_q <= 8'd1;
      busy_q     <= 1'b0;
      auto_q     <= 1'b0;
      cnt_q      <= '0;
      pattern_q  <= PAT_NONE;
      frame_q    <= '0;
      state_q    <= ST_IDLE;
      width_q    <= '0;
      first_q    <= 1'b1;
      valid_q    <= 1'b0;
      ramp_q     <= '0;
    end else begin
      vn_q       <= vn_d;
      vn_dly_q   <= vn_dly_d;
      fb_q       <= fb_d;
      auto_sh_q  <= auto_sh_d;
      pat_sh_q   <= pat_sh_d;
      dwell_sh_q <= dwell_sh_d;
      busy_q     <= busy_d;
      auto_q     <= auto_d;
      cnt_q      <= cnt_d;
      pattern_q  <= pattern_d;
      frame_q    <= frame_d;
      state_q    <= state_d;
      width_q    <= width_d;
      first_q    <= first_d;
      valid_q    <= valid_d;
      ramp_q     <= ramp_d;
    end
  end
  assign bus.cfg_busy    = busy_q;
  assign bus.pattern     = pattern_q;
  assign bus.ramp_step   = ramp_q;
  assign bus.step_valid  = valid_q;
  assign bus.frame_count = frame_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: randomized frame/config/width stimulus checked against an arithmetic reference.
module tb_pattern_sequencer;
  import pattern_sequencer_pkg::*;
  logic clk_in = 1'b0;
  logic reset_n;
  int n_checks = 0;
  int n_fail = 0;
  int exp_frames = 0;
  logic [19:0] exp_ramp = '0;
  pattern_sequencer_if bus ();
  pattern_sequencer dut (.clk_in(clk_in), .reset_n(reset_n), .bus(bus));
  always #5 clk_in = ~clk_in;

  function automatic logic [19:0] ref_step(input int w);
    if (w < 2) return 20'hFFFFF;
    return 20'((1 << 20) / w);
  endfunction

  task automatic gap(input int n);
    bus.vn_in = 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  // Outputs reflect the frame boundary once this returns.
  task automatic vsync();
    bus.vn_in = 1'b0;
    repeat (3) @(negedge clk_in);
    exp_frames++;
  endtask

  task automatic cfg(input logic a, input logic [7:0] p, input logic [7:0] d);
    bus.cfg_wr = 1'b1;
    bus.cfg_auto = a;
    bus.cfg_pattern = p;
    bus.cfg_dwell = d;
    @(negedge clk_in);
    bus.cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.total_active_pix = 13'd1920;
    repeat (4) @(negedge clk_in);
    n_checks++; if (bus.pattern !== 8'd0) begin n_fail++; $display("FAIL reset_pattern: got %0d want 0", bus.pattern); end
    n_checks++; if (bus.ramp_step !== 20'd0) begin n_fail++; $display("FAIL reset_ramp: got %0d want 0", bus.ramp_step); end
    n_checks++; if (bus.step_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.step_valid); end
    n_checks++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.cfg_busy); end
    n_checks++; if (bus.frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frames: got %0d want 0", bus.frame_count); end
    reset_n = 1'b1;
    exp_frames = 0;
    gap(30);
    vsync();
    exp_ramp = ref_step(1920);
    n_checks++; if (bus.ramp_step !== 20'd546) begin n_fail++; $display("FAIL first_ramp: got %0d want 546", bus.ramp_step); end
    n_checks++; if (bus.step_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", bus.step_valid); end
    n_checks++; if (bus.pattern !== 8'd0) begin n_fail++; $display("FAIL first_pattern: got %0d want 0", bus.pattern); end
    n_checks++; if (bus.frame_count !== 16'(exp_frames)) begin n_fail++; $display("FAIL first_frames: got %0d want %0d", bus.frame_count, exp_frames); end
    gap(20);
    vsync();
    n_checks++; if (bus.ramp_step !== exp_ramp) begin n_fail++; $display("FAIL second_ramp: got %0d want %0d", bus.ramp_step, exp_ramp); end
    gap(10);
  endtask

  task automatic test_width_change();
    bus.total_active_pix = 13'd1280;
    @(negedge clk_in);
    n_checks++; if (bus.step_valid !== 1'b0) begin n_fail++; $display("FAIL change_valid_drop: got %b want 0", bus.step_valid); end
    n_checks++; if (bus.ramp_step !== exp_ramp) begin n_fail++; $display("FAIL change_ramp_hold: got %0d want %0d", bus.ramp_step, exp_ramp); end
    gap(30);
    vsync();
    exp_ramp = ref_step(1280);
    n_checks++; if (bus.ramp_step !== 20'd819) begin n_fail++; $display("FAIL change_ramp: got %0d want 819", bus.ramp_step); end
    n_checks++; if (bus.step_valid !== 1'b1) begin n_fail++; $display("FAIL change_valid: got %b want 1", bus.step_valid); end
    gap(10);
  endtask

  task automatic test_degenerate();
    for (int i = 0; i < 3; i++) begin
      int w;
      w = (i == 0) ? 1 : (i == 1) ? 0 : 1920;
      bus.total_active_pix = 13'(w);
      gap(30);
      vsync();
      exp_ramp = ref_step(w);
      n_checks++; if (bus.ramp_step !== exp_ramp) begin n_fail++; $display("FAIL degen_ramp w=%0d: got %h want %h", w, bus.ramp_step, exp_ramp); end
      n_checks++; if (bus.step_valid !== 1'b1) begin n_fail++; $display("FAIL degen_valid w=%0d: got %b want 1", w, bus.step_valid); end
      gap(10);
    end
  endtask

  task automatic test_random_width();
    for (int i = 0; i < 5; i++) begin
      int w;
      w = int'($urandom_range(2, 8191));
      bus.total_active_pix = 13'(w);
      gap(30);
      vsync();
      exp_ramp = ref_step(w);
      n_checks++; if (bus.ramp_step !== exp_ramp) begin n_fail++; $display("FAIL rand_ramp w=%0d: got %0d want %0d", w, bus.ramp_step, exp_ramp); end
      n_checks++; if (bus.step_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid w=%0d: got %b want 1", w, bus.step_valid); end
      gap(10);
    end
  endtask

  task automatic test_stale();
    int a, b;
    a = int'($urandom_range(2, 8191));
    b = (a == 2) ? 3 : a - 1;
    bus.total_active_pix = 13'(a);
    gap(5);
    bus.total_active_pix = 13'(b);
    gap(30);
    vsync();
    n_checks++; if (bus.step_valid !== 1'b0) begin n_fail++; $display("FAIL stale_valid: got %b want 0", bus.step_valid); end
    n_checks++; if (bus.ramp_step !== exp_ramp) begin n_fail++; $display("FAIL stale_ramp: got %0d want %0d", bus.ramp_step, exp_ramp); end
    gap(30);
    vsync();
    exp_ramp = ref_step(b);
    n_checks++; if (bus.ramp_step !== exp_ramp) begin n_fail++; $display("FAIL restart_ramp w=%0d: got %0d want %0d", b, bus.ramp_step, exp_ramp); end
    n_checks++; if (bus.step_valid !== 1'b1) begin n_fail++; $display("FAIL restart_valid: got %b want 1", bus.step_valid); end
    gap(10);
  endtask

  task automatic test_manual();
    cfg(1'b0, 8'd3, 8'd1);
    n_checks++; if (bus.cfg_busy !== 1'b1) begin n_fail++; $display("FAIL manual_busy: got %b want 1", bus.cfg_busy); end
    n_checks++; if (bus.pattern !== 8'd0) begin n_fail++; $display("FAIL manual_early: got %0d want 0", bus.pattern); end
    gap(5);
    vsync();
    n_checks++; if (bus.pattern !== 8'd3) begin n_fail++; $display("FAIL manual_pattern: got %0d want 3", bus.pattern); end
    n_checks++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL manual_busy_clear: got %b want 0", bus.cfg_busy); end
    gap(20);
    bus.vn_in = 1'b0;
    repeat (2) @(negedge clk_in);
    cfg(1'b0, 8'd2, 8'd1);
    exp_frames++;
    n_checks++; if (bus.pattern !== 8'd3) begin n_fail++; $display("FAIL coincide_pattern: got %0d want 3", bus.pattern); end
    n_checks++; if (bus.cfg_busy !== 1'b1) begin n_fail++; $display("FAIL coincide_busy: got %b want 1", bus.cfg_busy); end
    gap(10);
    vsync();
    n_checks++; if (bus.pattern !== 8'd2) begin n_fail++; $display("FAIL coincide_applied: got %0d want 2", bus.pattern); end
    gap(10);
    cfg(1'b0, 8'd9, 8'd1);
    cfg(1'b0, 8'd200, 8'd1);
    gap(3);
    vsync();
    n_checks++; if (bus.pattern !== 8'd200) begin n_fail++; $display("FAIL last_write_wins: got %0d want 200", bus.pattern); end
    gap(10);
  endtask

  task automatic test_auto();
    for (int it = 0; it < 3; it++) begin
      int dw, d;
      dw = (it == 0) ? 2 : (it == 1) ? 0 : int'($urandom_range(1, 4));
      d = (dw == 0) ? 1 : dw;
      if (it != 0) begin
        cfg(1'b0, 8'd0, 8'd1);
        gap(3);
        vsync();
        gap(5);
      end
      cfg(1'b1, 8'd0, 8'(dw));
      gap(3);
      for (int k = 0; k < 12; k++) begin
        vsync();
        n_checks++; if (bus.pattern !== 8'((k / d) % 5)) begin n_fail++; $display("FAIL auto_seq dwell=%0d frame=%0d: got %0d want %0d", dw, k, bus.pattern, (k / d) % 5); end
        gap(8);
      end
    end
  endtask

  task automatic test_sync();
    bus.vn_in = 1'b0;
    repeat (2) @(negedge clk_in);
    n_checks++; if (bus.frame_count !== 16'(exp_frames)) begin n_fail++; $display("FAIL sync_latency: got %0d want %0d", bus.frame_count, exp_frames); end
    @(negedge clk_in);
    exp_frames++;
    n_checks++; if (bus.frame_count !== 16'(exp_frames)) begin n_fail++; $display("FAIL sync_update: got %0d want %0d", bus.frame_count, exp_frames); end
    repeat (97) @(negedge clk_in);
    n_checks++; if (bus.frame_count !== 16'(exp_frames)) begin n_fail++; $display("FAIL sync_held: got %0d want %0d", bus.frame_count, exp_frames); end
    gap(5);
    n_checks++; if (bus.frame_count !== 16'(exp_frames)) begin n_fail++; $display("FAIL sync_release: got %0d want %0d", bus.frame_count, exp_frames); end
  endtask

  task automatic test_reset_mid_div();
    cfg(1'b0, 8'd4, 8'd1);
    bus.total_active_pix = 13'd1000;
    gap(5);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_in);
    n_checks++; if (bus.pattern !== 8'd0) begin n_fail++; $display("FAIL rst_mid_pattern: got %0d want 0", bus.pattern); end
    n_checks++; if (bus.ramp_step !== 20'd0) begin n_fail++; $display("FAIL rst_mid_ramp: got %0d want 0", bus.ramp_step); end
    n_checks++; if (bus.step_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", bus.step_valid); end
    n_checks++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.cfg_busy); end
    n_checks++; if (bus.frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_frames: got %0d want 0", bus.frame_count); end
    reset_n = 1'b1;
    exp_frames = 0;
    gap(30);
    vsync();
    exp_ramp = ref_step(1000);
    n_checks++; if (bus.ramp_step !== exp_ramp) begin n_fail++; $display("FAIL rst_fresh_ramp: got %0d want %0d", bus.ramp_step, exp_ramp); end
    n_checks++; if (bus.step_valid !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_valid: got %b want 1", bus.step_valid); end
    n_checks++; if (bus.pattern !== 8'd0) begin n_fail++; $display("FAIL rst_fresh_pattern: got %0d want 0", bus.pattern); end
    n_checks++; if (bus.frame_count !== 16'(exp_frames)) begin n_fail++; $display("FAIL rst_fresh_frames: got %0d want %0d", bus.frame_count, exp_frames); end
    gap(10);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.vn_in = 1'b1;
    bus.total_active_pix = 13'd1920;
    bus.cfg_wr = 1'b0;
    bus.cfg_auto = 1'b0;
    bus.cfg_pattern = 8'd0;
    bus.cfg_dwell = 8'd1;
    test_reset();
    test_width_change();
    test_degenerate();
    test_random_width();
    test_stale();
    test_manual();
    test_auto();
    test_sync();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
